// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit-side controller for a UART. It buffers CPU bytes, hands them one at
// a time to an external Tx bit FSM, and generates the bit-period and half-bit
// enable pulses that pace that FSM.
//
// Build option: define UART_TX_FIFO_EN for an 8-entry transmit FIFO. Without
// it, the buffer is a single holding register.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_wr             CPU write strobe into the transmit buffer
//   i_wr_data[7:0]   CPU transmit byte
//   i_divisor[15:0]  baud divisor in clocks per bit (0 behaves as 1)
//   i_clear_overrun  clears o_overrun
//   i_tx_en_stop     Tx FSM idle indication, high = idle
//   o_tx_data[7:0]   byte presented to the Tx FSM
//   o_start_tx       one-cycle frame start pulse
//   o_tx_en          one-cycle bit-period enable pulse
//   o_tx_en_div2     one-cycle half-bit enable pulse
//   o_thr_empty      transmit buffer empty
//   o_full           transmit buffer full
//   o_overrun        sticky, a write was dropped because the buffer was full
// ---------------------------------------------------------------------------
module uart_tx_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic [7:0]  i_wr_data,
    input  logic [15:0] i_divisor,
    input  logic        i_clear_overrun,
    input  logic        i_tx_en_stop,
    output logic [7:0]  o_tx_data,
    output logic        o_start_tx,
    output logic        o_tx_en,
    output logic        o_tx_en_div2,
    output logic        o_thr_empty,
    output logic        o_full,
    output logic        o_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        start_q, start_d;
    logic        en_q, en_d;
    logic        en2_q, en2_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;
    logic        ovr_q, ovr_d;

    logic [15:0] div_in_s;
    logic        running_s;
    logic        pop_s;
    logic        push_s;
    logic        drop_s;
    logic [7:0]  head_s;

    // A zero divisor would stall the counter, so it is promoted to 1.
    assign div_in_s = (i_divisor == 16'd0) ? 16'd1 : i_divisor;

    // The only pop happens in LOAD; a write colliding with that pop frees a slot.
    assign pop_s  = (state_q == ST_LOAD);
    assign push_s = i_wr & (~full_q | pop_s);
    assign drop_s = i_wr & full_q & ~pop_s;

    // Controller next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && i_tx_en_stop) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:  state_d = ST_START;
            ST_START: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (!i_tx_en_stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (i_tx_en_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Baud counter, divisor latch, data latch and registered pulse outputs.
    always_comb begin
        tx_data_d = pop_s ? head_s : tx_data_q;
        start_d   = (state_d == ST_START);

        // The divisor is frozen at START so mid-frame changes wait for the next frame.
        if (state_q == ST_START) begin
            div_d = div_in_s;
        end else begin
            div_d = div_q;
        end

        case (state_q)
            ST_IDLE, ST_LOAD, ST_START: cnt_d = div_in_s - 16'd1;
            ST_ACTIVE, ST_DRAIN: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: cnt_d = 16'd0;
        endcase

        // Pulses are computed from next-cycle counter/state so the registered
        // outputs line up exactly with the cycle the counter holds the value.
        running_s = (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
        en_d      = running_s && (cnt_d == 16'd0);
        en2_d     = running_s && (cnt_d == (div_d >> 1));

        // Set wins over clear when both happen in one cycle.
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (i_clear_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Controller and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            div_q     <= 16'd1;
            tx_data_q <= 8'h00;
            start_q   <= 1'b0;
            en_q      <= 1'b0;
            en2_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            tx_data_q <= tx_data_d;
            start_q   <= start_d;
            en_q      <= en_d;
            en2_q     <= en2_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef UART_TX_FIFO_EN
    logic [7:0] mem_q [0:7];
    logic [7:0] mem_d [0:7];
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] count_q, count_d;

    assign head_s = mem_q[rd_ptr_q];

    // FIFO storage, pointers (3-bit, wrap naturally) and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d        = wr_ptr_q + 3'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == 4'd0);
        full_d  = (count_d == 4'd8);
    end

    // FIFO registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign head_s = hold_q;

    // Single holding register; a write during the pop refills it immediately.
    always_comb begin
        if (push_s) begin
            hold_d = i_wr_data;
        end else begin
            hold_d = hold_q;
        end
        case ({push_s, pop_s})
            2'b10:   valid_d = 1'b1;
            2'b01:   valid_d = 1'b0;
            default: valid_d = valid_q;
        endcase
        empty_d = ~valid_d;
        full_d  = valid_d;
    end

    // Holding register state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end
`endif

    assign o_tx_data    = tx_data_q;
    assign o_start_tx   = start_q;
    assign o_tx_en      = en_q;
    assign o_tx_en_div2 = en2_q;
    assign o_thr_empty  = empty_q;
    assign o_full       = full_q;
    assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. Inputs change 1 ns after the rising edge
// and outputs are sampled at that same point, well away from the next edge.
// The Tx bit FSM is modelled by hand through i_tx_en_stop.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_wr;
    logic [7:0]  i_wr_data;
    logic [15:0] i_divisor;
    logic        i_clear_overrun;
    logic        i_tx_en_stop;
    logic [7:0]  o_tx_data;
    logic        o_start_tx;
    logic        o_tx_en;
    logic        o_tx_en_div2;
    logic        o_thr_empty;
    logic        o_full;
    logic        o_overrun;

    int n_checks;
    int n_errors;

    uart_tx_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr            (i_wr),
        .i_wr_data       (i_wr_data),
        .i_divisor       (i_divisor),
        .i_clear_overrun (i_clear_overrun),
        .i_tx_en_stop    (i_tx_en_stop),
        .o_tx_data       (o_tx_data),
        .o_start_tx      (o_start_tx),
        .o_tx_en         (o_tx_en),
        .o_tx_en_div2    (o_tx_en_div2),
        .o_thr_empty     (o_thr_empty),
        .o_full          (o_full),
        .o_overrun       (o_overrun)
    );

    // 100 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Wait (bounded) for o_start_tx; returns clocks waited.
    task automatic wait_start(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (o_start_tx) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            check("start_timeout", 32'd0, 32'd1);
        end
    endtask

    // Run a frame after START is visible: pulse k (k = clocks after START)
    // expects o_tx_en when k%period==0 and o_tx_en_div2 when k%period==half_pos.
    task automatic frame_pulses(input int period, input int half_pos, input int n,
                                input logic [15:0] mid_div);
        i_tx_en_stop = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 1) begin
                i_divisor = mid_div;
                check("start_one_cycle", 32'(o_start_tx), 32'd0);
            end
            check("tx_en", 32'(o_tx_en), 32'((k % period) == 0));
            check("tx_en_div2", 32'(o_tx_en_div2), 32'((k % period) == half_pos));
        end
        i_tx_en_stop = 1'b1;
        tick();
        check("tx_en_after_stop", 32'(o_tx_en), 32'd0);
        check("div2_after_stop", 32'(o_tx_en_div2), 32'd0);
    endtask

    // Short frame used when only the byte order matters.
    task automatic quick_frame(input logic [7:0] exp_data);
        int lat;
        wait_start(lat);
        check("frame_data", 32'(o_tx_data), 32'(exp_data));
        i_tx_en_stop = 1'b0;
        tick();
        tick();
        i_tx_en_stop = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        i_wr      = 1'b1;
        i_wr_data = d;
        tick();
        i_wr      = 1'b0;
    endtask

    task automatic expect_no_start(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_start_tx) begin
                seen = 1'b1;
            end
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int   lat;
        logic seen;
        n_checks        = 0;
        n_errors        = 0;
        i_rst           = 1'b1;
        i_wr            = 1'b0;
        i_wr_data       = 8'h00;
        i_divisor       = 16'd4;
        i_clear_overrun = 1'b0;
        i_tx_en_stop    = 1'b1;

        // Reset values.
        tick();
        tick();
        i_rst = 1'b0;
        check("rst_tx_data", 32'(o_tx_data), 32'h00);
        check("rst_start", 32'(o_start_tx), 32'd0);
        check("rst_tx_en", 32'(o_tx_en), 32'd0);
        check("rst_div2", 32'(o_tx_en_div2), 32'd0);
        check("rst_empty", 32'(o_thr_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        tick();

        // Single byte, divisor 4.
        write_byte(8'hA5);
        check("empty_after_wr", 32'(o_thr_empty), 32'd0);
        wait_start(lat);
        check("start_latency", 32'(lat), 32'd2);
        check("tx_data_a5", 32'(o_tx_data), 32'hA5);
        frame_pulses(4, 2, 12, 16'd4);
        check("empty_after_frame", 32'(o_thr_empty), 32'd1);

        // Half-bit pulse, divisor 10.
        i_divisor = 16'd10;
        write_byte(8'h3C);
        wait_start(lat);
        check("tx_data_3c", 32'(o_tx_data), 32'h3C);
        frame_pulses(10, 5, 26, 16'd10);

        // Divisor 0 behaves as 1: both pulses every running cycle.
        i_divisor = 16'd0;
        write_byte(8'h5A);
        wait_start(lat);
        check("tx_data_5a", 32'(o_tx_data), 32'h5A);
        frame_pulses(1, 0, 4, 16'd0);

        i_divisor = 16'd1;
`ifdef UART_TX_FIFO_EN
        // Fill the FIFO while the FSM is held busy.
        i_tx_en_stop = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            i_wr      = 1'b1;
            i_wr_data = 8'(i);
            tick();
            if (i == 7) check("full_after_7", 32'(o_full), 32'd0);
            if (i == 8) check("full_after_8", 32'(o_full), 32'd1);
            if (i == 8) check("ovr_after_8", 32'(o_overrun), 32'd0);
        end
        i_wr = 1'b0;
        check("ovr_after_9", 32'(o_overrun), 32'd1);
        i_tx_en_stop = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            quick_frame(8'(i));
        end
        check("fifo_drained", 32'(o_thr_empty), 32'd1);
        expect_no_start("dropped_9th_sent", 12);

        i_clear_overrun = 1'b1;
        tick();
        i_clear_overrun = 1'b0;
        check("ovr_cleared", 32'(o_overrun), 32'd0);

        // Full FIFO plus a write during the LOAD pop.
        i_tx_en_stop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_byte(8'h11 + 8'(i));
        end
        check("refill_full", 32'(o_full), 32'd1);
        check("refill_ovr", 32'(o_overrun), 32'd0);
        i_tx_en_stop = 1'b1;
        tick();
        write_byte(8'hAA);
        check("pop_write_ovr", 32'(o_overrun), 32'd0);
        check("pop_write_full", 32'(o_full), 32'd1);
        check("pop_write_start", 32'(o_start_tx), 32'd1);
        check("pop_write_data", 32'(o_tx_data), 32'h11);
        i_tx_en_stop = 1'b0;
        tick();
        i_wr            = 1'b1;
        i_wr_data       = 8'hEE;
        i_clear_overrun = 1'b1;
        tick();
        i_wr            = 1'b0;
        i_clear_overrun = 1'b0;
        check("set_beats_clear", 32'(o_overrun), 32'd1);
        i_clear_overrun = 1'b1;
        tick();
        i_clear_overrun = 1'b0;
        check("clear_alone", 32'(o_overrun), 32'd0);
        i_tx_en_stop = 1'b1;
        tick();
        for (int i = 1; i < 8; i++) begin
            quick_frame(8'h11 + 8'(i));
        end
        quick_frame(8'hAA);
        check("refill_drained", 32'(o_thr_empty), 32'd1);
        expect_no_start("dropped_ee_sent", 12);
`else
        // Single holding register: second write while busy is dropped.
        i_tx_en_stop = 1'b0;
        write_byte(8'h21);
        check("hold_full", 32'(o_full), 32'd1);
        check("hold_not_empty", 32'(o_thr_empty), 32'd0);
        check("hold_ovr_0", 32'(o_overrun), 32'd0);
        write_byte(8'h22);
        check("hold_ovr_1", 32'(o_overrun), 32'd1);
        check("hold_still_full", 32'(o_full), 32'd1);
        i_tx_en_stop = 1'b1;
        quick_frame(8'h21);
        check("hold_drained", 32'(o_thr_empty), 32'd1);
        check("hold_full_clear", 32'(o_full), 32'd0);
        expect_no_start("dropped_22_sent", 12);
        i_clear_overrun = 1'b1;
        tick();
        i_clear_overrun = 1'b0;
        check("hold_ovr_cleared", 32'(o_overrun), 32'd0);
`endif

        // Divisor change mid-frame keeps period 4 until the next START.
        i_divisor = 16'd4;
        write_byte(8'h77);
        wait_start(lat);
        check("tx_data_77", 32'(o_tx_data), 32'h77);
        frame_pulses(4, 2, 12, 16'd8);
        write_byte(8'h78);
        wait_start(lat);
        check("tx_data_78", 32'(o_tx_data), 32'h78);
        frame_pulses(8, 4, 17, 16'd8);

        // Reset mid-frame aborts everything.
        write_byte(8'h99);
        wait_start(lat);
        i_tx_en_stop = 1'b0;
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_tx_en_stop = 1'b1;
        check("mid_rst_tx_data", 32'(o_tx_data), 32'h00);
        check("mid_rst_start", 32'(o_start_tx), 32'd0);
        check("mid_rst_tx_en", 32'(o_tx_en), 32'd0);
        check("mid_rst_div2", 32'(o_tx_en_div2), 32'd0);
        check("mid_rst_empty", 32'(o_thr_empty), 32'd1);
        check("mid_rst_full", 32'(o_full), 32'd0);
        check("mid_rst_overrun", 32'(o_overrun), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_start_tx || o_tx_en || o_tx_en_div2) begin
                seen = 1'b1;
            end
        end
        check("no_pulse_after_rst", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL use a single clock `i_clk`; reset `i_rst` is synchronous and active-high.
REQ-002 SHALL have these ports (name  dir  width  meaning):
  i_clk  in  1  system clock
  i_rst  in  1  synchronous active-high reset
  i_wr  in  1  CPU write strobe into transmit buffer
  i_wr_data  in  8  CPU transmit byte
  i_divisor  in  16  baud divisor, in clocks per bit
  i_clear_overrun  in  1  clears o_overrun
  i_tx_en_stop  in  1  Tx FSM idle indication; high = FSM idle
  o_tx_data  out  8  byte presented to Tx FSM
  o_start_tx  out  1  one-cycle frame start pulse to Tx FSM
  o_tx_en  out  1  one-cycle bit-period enable pulse
  o_tx_en_div2  out  1  one-cycle half-bit enable pulse
  o_thr_empty  out  1  transmit buffer empty
  o_full  out  1  transmit buffer full
  o_overrun  out  1  sticky; a write was dropped because the buffer was full

Function
REQ-003 SHALL implement controller states IDLE, LOAD, START, ACTIVE, DRAIN.
REQ-004 IDLE -> LOAD when the buffer is non-empty and i_tx_en_stop=1; otherwise SHALL stay in IDLE.
REQ-005 LOAD SHALL pop the buffer head into o_tx_data, then go to START.
REQ-006 START SHALL assert o_start_tx for exactly one cycle, latch divisor_eff, and go to ACTIVE.
REQ-007 ACTIVE -> DRAIN on the first cycle i_tx_en_stop=0; DRAIN -> IDLE on the first cycle i_tx_en_stop=1.
REQ-008 o_tx_data SHALL change only in LOAD and stay stable from START until the return to IDLE.
REQ-009 divisor_eff SHALL equal i_divisor, except i_divisor=0 SHALL be treated as 1; i_divisor changes after START SHALL NOT affect the frame in progress.
REQ-010 The 16-bit baud counter SHALL load divisor_eff-1 in IDLE, LOAD and START.
REQ-011 In ACTIVE and DRAIN the counter SHALL decrement each cycle and reload divisor_eff-1 after reaching 0.
REQ-012 o_tx_en SHALL be 1 exactly on cycles where the counter equals 0 in ACTIVE or DRAIN.
REQ-013 o_tx_en_div2 SHALL be 1 on cycles where the counter equals divisor_eff>>1 in ACTIVE or DRAIN; for divisor_eff=1 it SHALL equal o_tx_en.
REQ-014 A write when the buffer is not full SHALL be stored in FIFO order.
REQ-015 A write when the buffer is full SHALL be dropped and SHALL set o_overrun, unless the same cycle is a LOAD pop; that simultaneous write SHALL be accepted.
REQ-016 o_overrun SHALL clear on i_clear_overrun; if a dropped write occurs in the same cycle, set SHALL win.
REQ-017 o_thr_empty and o_full SHALL reflect the buffer occupancy registered at the end of the previous cycle; pointers SHALL wrap modulo depth.
REQ-018 Write data SHALL take at least 3 cycles from i_wr to o_start_tx (write, LOAD, START).

Reset
REQ-019 On i_rst the block SHALL apply these values:
  state = IDLE
  buffer empty, pointers = 0
  o_tx_data = 8'h00
  o_start_tx = o_tx_en = o_tx_en_div2 = 0
  o_thr_empty = 1, o_full = 0, o_overrun = 0
  counter = 0
REQ-020 Reset asserted mid-frame SHALL abort immediately; no o_start_tx or enable pulse SHALL follow until a new write.

Configuration
REQ-021 Macro `UART_TX_FIFO_EN` defined: the buffer SHALL be an 8-entry FIFO with 3-bit pointers and a 4-bit count.
REQ-022 Macro `UART_TX_FIFO_EN` undefined: the buffer SHALL be a single holding register (depth 1), with o_full = !o_thr_empty; all other behaviour is unchanged.

Verification
REQ-023 Single byte: reset, i_divisor=4, write 8'hA5, FSM model idle.
  -> o_start_tx one cycle, 2 cycles after the write
  -> o_tx_data=8'hA5
  -> o_tx_en every 4th cycle until i_tx_en_stop returns high
REQ-024 Half-bit pulse: i_divisor=10.
  -> o_tx_en_div2 fires 5 cycles after each o_tx_en
  -> i_divisor=0 gives o_tx_en=o_tx_en_div2=1 on every ACTIVE/DRAIN cycle
REQ-025 FIFO fill (with UART_TX_FIFO_EN): 9 back-to-back writes 8'h01..8'h09 while the FSM is busy.
  -> o_full after the 8th write
  -> 9th write dropped, o_overrun=1
  -> frames output 8'h01..8'h08 in order
REQ-026 Full plus simultaneous pop: write in the same cycle as LOAD while full.
  -> write accepted, o_overrun stays 0
  -> i_clear_overrun together with a dropped write leaves o_overrun=1
REQ-027 Mid-frame change and reset: change i_divisor from 4 to 8 mid-frame.
  -> period stays 4 until the next START
  -> i_rst mid-frame returns all outputs to REQ-019 values on the next cycle
REQ-028 No FIFO (UART_TX_FIFO_EN undefined): 2 writes while the FSM is busy.
  -> second write dropped, o_overrun=1
  -> o_full=1 after the first write
